// File: rtl/lock_ctrl.sv
// Digital-lock controller: detects debounced button presses, programs a code,
// checks entries against it, enforces a timed lockout, and drives a 2-bit status.
module lock_ctrl #(
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       lock,
  input  logic       clear,
  output logic [1:0] status,
  output logic [2:0] digit_count,
  output logic [3:0] fail_count
);

  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int EW = CODE_LEN * 4;

  typedef enum logic [1:0] {
    ST_INIT     = 2'b00,
    ST_LOCKED   = 2'b01,
    ST_UNLOCKED = 2'b10,
    ST_LOCKOUT  = 2'b11
  } state_t;

  // Buttons are {clear, lock, enter}. The sampled copy and its history both
  // reset to 1 so a button already high at reset release never fires.
  logic [2:0]    btn_s_q, btn_s_d;
  logic [2:0]    btn_prev_q, btn_prev_d;
  logic [3:0]    digit_s_q, digit_s_d;
  state_t        state_q, state_d;
  logic [2:0]    digit_count_q, digit_count_d;
  logic [3:0]    fail_count_q, fail_count_d;
  logic [EW-1:0] code_q, code_d;
  logic [EW-1:0] entry_q, entry_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  logic [2:0]    press;
  logic          press_enter, press_lock, press_clear;
  logic          accept, last_digit;
  logic [EW-1:0] entry_full;
  logic [3:0]    fail_inc;

  always_comb begin
    btn_s_d       = {clear, lock, enter};
    btn_prev_d    = btn_s_q;
    digit_s_d     = digit;
    state_d       = state_q;
    digit_count_d = digit_count_q;
    fail_count_d  = fail_count_q;
    code_d        = code_q;
    entry_d       = entry_q;
    lock_cnt_d    = lock_cnt_q;

    press       = btn_s_q & ~btn_prev_q;
    press_enter = press[0];
    press_lock  = press[1];
    press_clear = press[2];
    accept      = press_enter && (digit_s_q <= 4'd9);
    last_digit  = (digit_count_q == 3'(CODE_LEN - 1));
    fail_inc    = (fail_count_q == 4'(MAX_TRIES)) ? fail_count_q : fail_count_q + 4'd1;

    // Entry with the incoming digit merged in, so the final digit is compared
    // in the same cycle it is accepted.
    entry_full = entry_q;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_count_q == 3'(i)) entry_full[i*4 +: 4] = digit_s_q;
    end

    case (state_q)
      ST_INIT: begin
        if (press_clear) begin
          digit_count_d = 3'd0;
        end else if (accept) begin
          entry_d = entry_full;
          if (last_digit) begin
            code_d        = entry_full;
            digit_count_d = 3'd0;
            state_d       = ST_LOCKED;
          end else begin
            digit_count_d = digit_count_q + 3'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (press_clear) begin
          digit_count_d = 3'd0;
        end else if (accept) begin
          entry_d = entry_full;
          if (last_digit) begin
            digit_count_d = 3'd0;
            if (entry_full == code_q) begin
              state_d      = ST_UNLOCKED;
              fail_count_d = 4'd0;
            end else begin
              fail_count_d = fail_inc;
              if (fail_inc == 4'(MAX_TRIES)) begin
                state_d    = ST_LOCKOUT;
                lock_cnt_d = CW'(LOCKOUT_CYCLES - 1);
              end
            end
          end else begin
            digit_count_d = digit_count_q + 3'd1;
          end
        end
      end
      ST_UNLOCKED: begin
        if (press_lock) begin
          state_d = ST_LOCKED;
        end else if (press_clear) begin
          state_d      = ST_INIT;
          code_d       = '0;
          fail_count_d = 4'd0;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q == '0) begin
          state_d       = ST_LOCKED;
          fail_count_d  = 4'd0;
          digit_count_d = 3'd0;
        end else begin
          lock_cnt_d = lock_cnt_q - CW'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s_q       <= 3'b111;
      btn_prev_q    <= 3'b111;
      digit_s_q     <= 4'd0;
      state_q       <= ST_INIT;
      digit_count_q <= 3'd0;
      fail_count_q  <= 4'd0;
      code_q        <= '0;
      entry_q       <= '0;
      lock_cnt_q    <= '0;
    end else begin
      btn_s_q       <= btn_s_d;
      btn_prev_q    <= btn_prev_d;
      digit_s_q     <= digit_s_d;
      state_q       <= state_d;
      digit_count_q <= digit_count_d;
      fail_count_q  <= fail_count_d;
      code_q        <= code_d;
      entry_q       <= entry_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

  assign status      = state_q;
  assign digit_count = digit_count_q;
  assign fail_count  = fail_count_q;

endmodule
